mem_cmd_sequencer: RTL and testbench
====================================

// Module: mem_cmd_sequencer
// PURPOSE
//  Parametrised command sequencer for the memory checker; successor to the single-mode test controller.
//  Samples a test configuration on start, issues COUNT write/read commands to the transaction block over valid/ready, then waits for downstream blocks to drain.
//  Adds DEC and strided INC addressing, a seedable LFSR, abort, a 2-bit result code and an issued-command counter.
// PARAMETERS
//  ADDR_W     32           word-address width of op_addr_o
//  CNT_W      16           width of the command count and of the issued counter
//  BURST_W    11           width of op_burst_o and cfg_burst_i
//  LFSR_TAPS  32'h80200003 Fibonacci feedback mask; only bits [ADDR_W-1:0] are used
// PORTS
//  clk_i            in   1        clock
//  rst_i            in   1        reset, asynchronous, active-high
//  start_i          in   1        start pulse; ignored unless the FSM is in IDLE
//  abort_i          in   1        level; stop issuing and drain
//  err_i            in   1        compare-mismatch pulse from the checker
//  busy_i           in   1        OR of the downstream busy flags
//  cfg_mode_i       in   2        0 WRITE_ONLY, 1 READ_ONLY, 2 WRITE_AND_CHECK, 3 reserved (same as 0)
//  cfg_addr_mode_i  in   3        0 FIX, 1 RND, 2 RUN_0, 3 RUN_1, 4 INC, 5 DEC, 6-7 same as FIX
//  cfg_count_i      in   CNT_W    number of commands; number of write+read pairs in WRITE_AND_CHECK
//  cfg_base_i       in   ADDR_W   FIX address, INC/DEC start address, LFSR seed
//  cfg_stride_i     in   ADDR_W   INC/DEC step
//  cfg_burst_i      in   BURST_W  burst length; passed to op_burst_o unchanged
//  op_valid_o       out  1        command valid
//  op_ready_i       in   1        command accepted when op_valid_o && op_ready_i
//  op_write_o       out  1        1 = write, 0 = read
//  op_addr_o        out  ADDR_W   command address
//  op_burst_o       out  BURST_W  command burst length
//  busy_o           out  1        high in every state except IDLE
//  done_o           out  1        1-cycle pulse when the test finishes
//  result_o         out  2        0 PASS, 1 ERROR, 2 ABORTED; held until the next accepted start
//  issued_o         out  CNT_W    accepted commands; a write+read pair counts once
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, LFSR all ones.
//  Start in IDLE: register every cfg_* input; they have no effect mid-test.
//    issued_o<=0 and result_o<=0. Next state: WR, RD or PAIR_WR by cfg_mode_i.
//  Start with cfg_count_i==0: go directly to DRAIN; no command is issued.
//  Command fire = op_valid_o && op_ready_i.
//    op_valid_o rises 1 cycle after state entry.
//    While op_valid_o=1 and op_ready_i=0, op_write_o, op_addr_o and op_burst_o are held stable.
//    Back-to-back: a new command is presented the cycle after a fire, with no bubble.
//  States:
//    IDLE
//    WR / RD: leave after the COUNT-th fire.
//    PAIR_WR -> PAIR_RD: read uses the address of the preceding write.
//      Address advances only after the read fires.
//    DRAIN: op_valid_o=0; wait for busy_i=0.
//    FINISH: 1 cycle; done_o=1; back to IDLE.
//  After the last fire, op_valid_o is 0 on the next cycle; the FSM enters DRAIN.
//  Address sequence (the first command uses the initial value):
//    FIX   = base.
//    INC   = base + k*stride, DEC = base - k*stride, both mod 2^ADDR_W (wrap silently).
//    RUN_0 initial ~1, RUN_1 initial 1; both rotate left by 1 per advance.
//    RND: seed = base, or all ones if base==0; shift left and insert XOR-reduce(lfsr & LFSR_TAPS).
//  err_i=1 in any non-IDLE state:
//    result_o<=ERROR (sticky, even if abort also occurs).
//    In an issuing state: go to DRAIN, op_valid_o<=0 next cycle.
//    A fire in that same cycle still counts in issued_o.
//  abort_i=1 in an issuing state: same as err_i, but result_o<=ABORTED unless already ERROR.
//    err_i and abort_i in the same cycle: ERROR wins.
//  err_i or abort_i in IDLE: ignored.
//  start_i in a non-IDLE state: ignored.
//  issued_o saturates at 2^CNT_W-1.
//  Reset mid-test: all outputs return to reset values immediately; no done_o.
// TESTING
//  T1: mode WRITE_ONLY, INC, base=0x10, stride=4, count=3, ready=1 ->
//      writes to 0x10,0x14,0x18 on consecutive cycles; done_o 1 cycle after busy_i=0; result 0; issued 3.
//  T2: mode WRITE_AND_CHECK, FIX base=0x40, count=2, ready toggling ->
//      W40,R40,W40,R40; fields stable while stalled; issued 2.
//  T3: mode READ_ONLY, DEC, base=0x2, stride=1, ADDR_W=8, count=4 ->
//      0x02,0x01,0x00,0xFF (wrap).
//  T4: mode READ_ONLY, RND, base=0, count=5 ->
//      first address all ones; next addresses match the reference LFSR model; after reset, same sequence.
//  T5: count=100; err_i at fire 7 while abort_i=1 ->
//      valid drops the next cycle; issued 7; result 1; done_o after busy_i falls.
//  T6: count=0 -> no valid ever; done_o once busy_i=0; result 0.
//      start_i during DRAIN -> ignored.

Source files
------------

// File: rtl/mem_cmd_sequencer.sv
// mem_cmd_sequencer: issues COUNT write/read commands over valid/ready with configurable addressing, then drains.
module mem_cmd_sequencer #(
  parameter int          ADDR_W    = 32,
  parameter int          CNT_W     = 16,
  parameter int          BURST_W   = 11,
  parameter logic [31:0] LFSR_TAPS = 32'h80200003
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               err_i,
  input  logic               busy_i,
  input  logic [1:0]         cfg_mode_i,
  input  logic [2:0]         cfg_addr_mode_i,
  input  logic [CNT_W-1:0]   cfg_count_i,
  input  logic [ADDR_W-1:0]  cfg_base_i,
  input  logic [ADDR_W-1:0]  cfg_stride_i,
  input  logic [BURST_W-1:0] cfg_burst_i,
  output logic               op_valid_o,
  input  logic               op_ready_i,
  output logic               op_write_o,
  output logic [ADDR_W-1:0]  op_addr_o,
  output logic [BURST_W-1:0] op_burst_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [1:0]         result_o,
  output logic [CNT_W-1:0]   issued_o
);
  typedef enum logic [2:0] {IDLE, WR, RD, PAIR_WR, PAIR_RD, DRAIN, FINISH} state_e;
  localparam logic [ADDR_W-1:0] TAPS = ADDR_W'(LFSR_TAPS);
  state_e             state_q, state_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, lfsr_q, lfsr_d, stride_q, stride_d;
  logic [CNT_W-1:0]   rem_q, rem_d, issued_q, issued_d;
  logic [1:0]         result_q, result_d;
  logic [2:0]         amode_q, amode_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               fire, issuing, cmd_done, last;
  logic [ADDR_W-1:0]  addr_adv, lfsr_adv;
  always_comb begin
    fire     = valid_q & op_ready_i;
    issuing  = state_q inside {WR, RD, PAIR_WR, PAIR_RD};
    // a write+read pair completes only when its read fires
    cmd_done = fire & (state_q != PAIR_WR);
    last     = cmd_done & (rem_q == CNT_W'(1));
    addr_adv = amode_q == 3'd4 ? addr_q + stride_q :
               amode_q == 3'd5 ? addr_q - stride_q :
               amode_q inside {3'd2, 3'd3} ? {addr_q[ADDR_W-2:0], addr_q[ADDR_W-1]} : addr_q;
    lfsr_adv = {lfsr_q[ADDR_W-2:0], ^(lfsr_q & TAPS)};
    state_d  = state_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    lfsr_d   = lfsr_q;
    stride_d = stride_q;
    rem_d    = rem_q;
    issued_d = issued_q;
    result_d = result_q;
    amode_d  = amode_q;
    burst_d  = burst_q;
    case (state_q)
      IDLE: if (start_i) begin
        amode_d  = cfg_addr_mode_i;
        stride_d = cfg_stride_i;
        burst_d  = cfg_burst_i;
        rem_d    = cfg_count_i;
        issued_d = '0;
        result_d = 2'd0;
        valid_d  = 1'b0;
        addr_d   = cfg_addr_mode_i == 3'd2 ? ~ADDR_W'(1) :
                   cfg_addr_mode_i == 3'd3 ? ADDR_W'(1) : cfg_base_i;
        lfsr_d   = cfg_base_i == '0 ? '1 : cfg_base_i;
        state_d  = cfg_count_i == '0 ? DRAIN :
                   cfg_mode_i == 2'd1 ? RD : cfg_mode_i == 2'd2 ? PAIR_WR : WR;
      end
      WR, RD, PAIR_WR, PAIR_RD: begin
        valid_d = 1'b1;
        if (fire && state_q == PAIR_WR) state_d = PAIR_RD;
        if (cmd_done) begin
          rem_d    = rem_q - CNT_W'(1);
          issued_d = issued_q + CNT_W'(issued_q != '1);
          addr_d   = addr_adv;
          lfsr_d   = lfsr_adv;
          if (state_q == PAIR_RD) state_d = PAIR_WR;
        end
        if (last || err_i || abort_i) begin
          state_d = DRAIN;
          valid_d = 1'b0;
        end
      end
      DRAIN:   if (!busy_i) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && err_i) result_d = 2'd1;
    else if (issuing && abort_i && result_q != 2'd1) result_d = 2'd2;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      lfsr_q   <= '1;
      stride_q <= '0;
      rem_q    <= '0;
      issued_q <= '0;
      result_q <= 2'd0;
      amode_q  <= 3'd0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      lfsr_q   <= lfsr_d;
      stride_q <= stride_d;
      rem_q    <= rem_d;
      issued_q <= issued_d;
      result_q <= result_d;
      amode_q  <= amode_d;
      burst_q  <= burst_d;
    end
  end
  assign op_valid_o = valid_q;
  assign op_write_o = state_q inside {WR, PAIR_WR};
  assign op_addr_o  = amode_q == 3'd1 ? lfsr_q : addr_q;
  assign op_burst_o = burst_q;
  assign busy_o     = state_q != IDLE;
  assign done_o     = state_q == FINISH;
  assign result_o   = result_q;
  assign issued_o   = issued_q;
endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// tb_mem_cmd_sequencer: scoreboard bench; stimulus queues expected commands/results, a negedge monitor checks them.
module tb_mem_cmd_sequencer;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        start_i = 1'b0, abort_i = 1'b0, err_i = 1'b0, busy_i = 1'b0;
  logic [1:0]  cfg_mode_i = '0;
  logic [2:0]  cfg_addr_mode_i = '0;
  logic [15:0] cfg_count_i = '0;
  logic [7:0]  cfg_base_i = '0, cfg_stride_i = '0;
  logic [10:0] cfg_burst_i = '0;
  logic        op_valid_o, op_ready_i = 1'b1, op_write_o, busy_o, done_o;
  logic [7:0]  op_addr_o;
  logic [10:0] op_burst_o;
  logic [1:0]  result_o;
  logic [15:0] issued_o;
  int checks = 0, failures = 0, fires = 0, lat;
  bit ign = 1'b0, hold_v = 1'b0;
  logic [19:0] hold;
  logic [19:0] exp_q[$];
  logic [17:0] res_q[$];

  mem_cmd_sequencer #(.ADDR_W(8), .CNT_W(16), .BURST_W(11)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i), .err_i(err_i),
    .busy_i(busy_i), .cfg_mode_i(cfg_mode_i), .cfg_addr_mode_i(cfg_addr_mode_i),
    .cfg_count_i(cfg_count_i), .cfg_base_i(cfg_base_i), .cfg_stride_i(cfg_stride_i),
    .cfg_burst_i(cfg_burst_i), .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
    .op_write_o(op_write_o), .op_addr_o(op_addr_o), .op_burst_o(op_burst_o),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .issued_o(issued_o));

  always #5 clk_i = ~clk_i;

  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  function automatic void push_cmd(logic w, logic [7:0] a, logic [10:0] b);
    exp_q.push_back({w, a, b});
  endfunction

  always @(negedge clk_i) begin
    if (rst_i || ign) hold_v = 1'b0;
    else begin
      if (hold_v && op_valid_o) chk("stall_hold", {op_write_o, op_addr_o, op_burst_o}, hold);
      hold_v = op_valid_o && !op_ready_i;
      hold   = {op_write_o, op_addr_o, op_burst_o};
      if (op_valid_o && op_ready_i) begin
        fires++;
        if (exp_q.size() == 0) chk("unexpected_cmd", {op_write_o, op_addr_o, op_burst_o}, 20'hFFFFF);
        else chk("cmd", {op_write_o, op_addr_o, op_burst_o}, exp_q.pop_front());
      end
      if (done_o) begin
        if (res_q.size() == 0) chk("unexpected_done", {result_o, issued_o}, 18'h3FFFF);
        else chk("result_issued", {result_o, issued_o}, res_q.pop_front());
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    while (n < 300) begin
      @(negedge clk_i);
      n++;
      if (done_o) break;
    end
    if (!done_o) begin
      failures++;
      $display("FAIL done_timeout: got no done_o within %0d cycles", n);
    end
    @(negedge clk_i);
    chk("done_pulse", done_o, 1'b0);
  endtask

  task automatic do_start(logic [1:0] m, logic [2:0] am, logic [15:0] cnt,
                          logic [7:0] base, logic [7:0] stride, logic [10:0] burst);
    cfg_mode_i = m; cfg_addr_mode_i = am; cfg_count_i = cnt;
    cfg_base_i = base; cfg_stride_i = stride; cfg_burst_i = burst;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cfg_count_i = 16'd9; cfg_base_i = 8'hA5; cfg_mode_i = 2'd2;
  endtask

  task automatic run_test(logic [1:0] m, logic [2:0] am, logic [15:0] cnt, logic [7:0] base,
                          logic [7:0] stride, logic [10:0] burst, bit tog, int bcyc, output int l);
    busy_i = 1'b1;
    op_ready_i = !tog;
    do_start(m, am, cnt, base, stride, burst);
    for (int c = 0; c < bcyc; c++) begin
      @(posedge clk_i); #1;
      if (tog) op_ready_i = ~op_ready_i;
    end
    busy_i = 1'b0;
    op_ready_i = 1'b1;
    wait_done(l);
  endtask

  task automatic check_reset_outputs(string n);
    chk(n, {op_valid_o, op_write_o, op_addr_o, op_burst_o, busy_o, done_o, result_o, issued_o}, '0);
  endtask

  task automatic t4_rnd();
    push_cmd(1'b0, 8'hFF, 11'd2); push_cmd(1'b0, 8'hFE, 11'd2); push_cmd(1'b0, 8'hFD, 11'd2);
    push_cmd(1'b0, 8'hFB, 11'd2); push_cmd(1'b0, 8'hF6, 11'd2);
    res_q.push_back({2'd0, 16'd5});
    run_test(2'd1, 3'd1, 16'd5, 8'h00, 8'h00, 11'd2, 1'b0, 10, lat);
  endtask

  initial begin
    #22;
    check_reset_outputs("reset_values");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_reset_outputs("post_reset_idle");
    // T1: write-only INC
    push_cmd(1'b1, 8'h10, 11'd5); push_cmd(1'b1, 8'h14, 11'd5); push_cmd(1'b1, 8'h18, 11'd5);
    res_q.push_back({2'd0, 16'd3});
    run_test(2'd0, 3'd4, 16'd3, 8'h10, 8'h04, 11'd5, 1'b0, 6, lat);
    chk("t1_done_latency", lat, 2);
    chk("t1_result_held", {result_o, issued_o}, {2'd0, 16'd3});
    // T2: write-and-check, FIX, stalls
    for (int i = 0; i < 2; i++) begin
      push_cmd(1'b1, 8'h40, 11'd7); push_cmd(1'b0, 8'h40, 11'd7);
    end
    res_q.push_back({2'd0, 16'd2});
    run_test(2'd2, 3'd0, 16'd2, 8'h40, 8'h00, 11'd7, 1'b1, 14, lat);
    // T3: read-only DEC with wrap
    push_cmd(1'b0, 8'h02, 11'd1); push_cmd(1'b0, 8'h01, 11'd1);
    push_cmd(1'b0, 8'h00, 11'd1); push_cmd(1'b0, 8'hFF, 11'd1);
    res_q.push_back({2'd0, 16'd4});
    run_test(2'd1, 3'd5, 16'd4, 8'h02, 8'h01, 11'd1, 1'b0, 8, lat);
    // RUN_1 rotate-left
    push_cmd(1'b1, 8'h01, 11'd0); push_cmd(1'b1, 8'h02, 11'd0); push_cmd(1'b1, 8'h04, 11'd0);
    res_q.push_back({2'd0, 16'd3});
    run_test(2'd3, 3'd3, 16'd3, 8'h77, 8'h00, 11'd0, 1'b0, 7, lat);
    // T4: RND, then mid-test reset, then same RND sequence again
    t4_rnd();
    busy_i = 1'b1;
    ign = 1'b1;
    do_start(2'd0, 3'd4, 16'd100, 8'h00, 8'h01, 11'd9);
    repeat (4) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1 check_reset_outputs("mid_test_reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    ign = 1'b0;
    chk("no_done_after_reset", done_o, 1'b0);
    t4_rnd();
    // T5: err and abort together at the 7th fire
    for (int i = 0; i < 7; i++) push_cmd(1'b1, 8'(i), 11'd3);
    res_q.push_back({2'd1, 16'd7});
    busy_i = 1'b1; op_ready_i = 1'b1; fires = 0;
    do_start(2'd0, 3'd4, 16'd100, 8'h00, 8'h01, 11'd3);
    for (int n = 0; n < 50 && fires < 6; n++) begin
      @(negedge clk_i); #1;
    end
    chk("t5_reached_fire6", fires, 6);
    @(posedge clk_i); #1;
    err_i = 1'b1; abort_i = 1'b1;
    @(posedge clk_i); #1;
    err_i = 1'b0; abort_i = 1'b0;
    @(negedge clk_i);
    chk("t5_valid_drop", op_valid_o, 1'b0);
    chk("t5_still_busy", busy_o, 1'b1);
    repeat (3) @(posedge clk_i);
    #1 busy_i = 1'b0;
    wait_done(lat);
    // T6: count 0, restart ignored while draining
    res_q.push_back({2'd0, 16'd0});
    busy_i = 1'b1;
    do_start(2'd0, 3'd0, 16'd0, 8'h33, 8'h00, 11'd4);
    repeat (2) @(posedge clk_i);
    #1 do_start(2'd0, 3'd0, 16'd3, 8'h55, 8'h00, 11'd4);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("t6_draining", {busy_o, op_valid_o, done_o}, 3'b100);
    #4 busy_i = 1'b0;
    wait_done(lat);
    repeat (5) @(negedge clk_i);
    chk("t6_idle", {busy_o, op_valid_o}, 2'b00);
    chk("exp_cmds_drained", exp_q.size(), 0);
    chk("exp_results_drained", res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000 expected earlier");
    $fatal(1);
  end
endmodule
